// File: rtl/unit_pool_scheduler.sv
// Round-robin scheduler that hands out a pool of identical worker units to
// requesters, tracks ownership until each unit reports done, then notifies the owner.
module unit_pool_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_UNITS = 3,
    localparam int RW = (NUM_REQ   > 1) ? $clog2(NUM_REQ)   : 1,
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [UW-1:0]           gnt_unit,
    output logic [NUM_UNITS-1:0]    unit_start,
    input  logic [NUM_UNITS-1:0]    unit_done,
    output logic [NUM_UNITS-1:0]    unit_busy,
    output logic [NUM_UNITS*RW-1:0] unit_owner,
    output logic [NUM_REQ-1:0]      done_to_req,
    output logic                    err_spurious
);

    logic [RW-1:0]           ptr;
    logic [NUM_REQ-1:0]      owned;
    logic [NUM_REQ-1:0]      eligible;

    logic                    req_found;
    logic [RW-1:0]           sel_req;
    logic                    unit_found;
    logic [UW-1:0]           sel_unit;
    logic                    do_grant;

    logic [RW-1:0]           ptr_nxt;
    logic [NUM_REQ-1:0]      owned_nxt;
    logic [NUM_REQ-1:0]      gnt_nxt;
    logic [UW-1:0]           gnt_unit_nxt;
    logic [NUM_UNITS-1:0]    start_nxt;
    logic [NUM_UNITS-1:0]    busy_nxt;
    logic [NUM_UNITS*RW-1:0] owner_nxt;
    logic [NUM_REQ-1:0]      done_nxt;
    logic                    err_nxt;

    assign eligible = req & ~owned;

    always_comb begin
        req_found = 1'b0;
        sel_req   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!req_found && eligible[(int'(ptr) + k) % NUM_REQ]) begin
                req_found = 1'b1;
                sel_req   = RW'((int'(ptr) + k) % NUM_REQ);
            end
        end

        // Descending scan so the lowest-index free unit wins.
        unit_found = 1'b0;
        sel_unit   = '0;
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
            if (!unit_busy[u]) begin
                unit_found = 1'b1;
                sel_unit   = UW'(u);
            end
        end

        do_grant = enable && req_found && unit_found;
    end

    always_comb begin
        ptr_nxt      = ptr;
        owned_nxt    = owned;
        gnt_nxt      = '0;
        gnt_unit_nxt = '0;
        start_nxt    = '0;
        busy_nxt     = unit_busy & ~unit_done;
        owner_nxt    = unit_owner;
        done_nxt     = '0;
        err_nxt      = err_spurious | (|(unit_done & ~unit_busy));

        for (int u = 0; u < NUM_UNITS; u++) begin
            if (unit_done[u] && unit_busy[u]) begin
                owned_nxt[unit_owner[u*RW +: RW]] = 1'b0;
                done_nxt[unit_owner[u*RW +: RW]]  = 1'b1;
                owner_nxt[u*RW +: RW]             = '0;
            end
        end

        // The granted unit was idle this cycle, so it never collides with a release.
        if (do_grant) begin
            gnt_nxt[sel_req]                   = 1'b1;
            gnt_unit_nxt                       = sel_unit;
            start_nxt[sel_unit]                = 1'b1;
            busy_nxt[sel_unit]                 = 1'b1;
            owner_nxt[int'(sel_unit)*RW +: RW] = sel_req;
            owned_nxt[sel_req]                 = 1'b1;
            ptr_nxt = (int'(sel_req) == NUM_REQ - 1) ? '0 : sel_req + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr          <= '0;
            owned        <= '0;
            gnt          <= '0;
            gnt_unit     <= '0;
            unit_start   <= '0;
            unit_busy    <= '0;
            unit_owner   <= '0;
            done_to_req  <= '0;
            err_spurious <= 1'b0;
        end else begin
            ptr          <= ptr_nxt;
            owned        <= owned_nxt;
            gnt          <= gnt_nxt;
            gnt_unit     <= gnt_unit_nxt;
            unit_start   <= start_nxt;
            unit_busy    <= busy_nxt;
            unit_owner   <= owner_nxt;
            done_to_req  <= done_nxt;
            err_spurious <= err_nxt;
        end
    end

endmodule

// File: doc/unit_pool_scheduler.md
Name: unit_pool_scheduler

Overview:
Shares a fixed pool of identical worker units, such as the three-wide bot1 array inside mid2, among several requesters. It grants at most one free unit per cycle to a round-robin-selected requester and issues a start pulse to that unit. It tracks ownership until the unit signals done, then frees the unit and notifies the owner. It sits one level above the unit array, in the mid-level wrapper that instantiates the pool.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16
NUM_UNITS, 3, number of pooled units; legal range 1..8
RW, $clog2(NUM_REQ) (minimum 1), requester index width; derived, do not override
UW, $clog2(NUM_UNITS) (minimum 1), unit index width; derived, do not override

Ports:
clk  in  1  single clock; all logic is on the rising edge
rst_n  in  1  synchronous active-low reset, sampled on the clk rising edge
enable  in  1  when 0, no new grants are made; done processing continues
req  in  NUM_REQ  level request per requester; held until granted or withdrawn
gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
gnt_unit  out  UW  index of the unit granted; valid only while gnt != 0, otherwise 0
unit_start  out  NUM_UNITS  one-hot, one-cycle start pulse to the granted unit
unit_done  in  NUM_UNITS  per-unit one-cycle completion pulse
unit_busy  out  NUM_UNITS  1 while the unit is owned
unit_owner  out  NUM_UNITS*RW  owner index per unit, packed as unit u at bits [u*RW +: RW]; 0 when the unit is idle
done_to_req  out  NUM_REQ  one-cycle notify pulse to the owner of a completed unit
err_spurious  out  1  sticky; set by a done pulse on an idle unit

Behaviour:
- Reset (rst_n=0 at an edge): all outputs are 0, the round-robin pointer is 0 and all owned flags are 0.
  - Reset mid-operation abandons all ownership. No done_to_req pulses are issued for units that were owned.
- Every output is registered.
- Eligibility: requester i is eligible if req[i]=1 and owned[i]=0. Each requester may hold at most one unit.
- Decision in cycle N: a grant is made when all of the following hold:
  - enable=1
  - at least one requester is eligible
  - at least one unit has unit_busy=0, using the registered value from cycle N
- Requester selection: the first eligible index, searching from ptr upward with wrap at NUM_REQ-1 → 0.
- Unit selection: the lowest-index free unit.
- Result at N+1 for requester i and unit u:
  - gnt[i]=1, gnt_unit=u, unit_start[u]=1
  - unit_busy[u]=1, unit_owner[u]=i, owned[i]=1
  - ptr=(i+1) mod NUM_REQ
  - Grant latency is 1 cycle from a sampled req.
- When no grant is made, ptr is unchanged and gnt, unit_start and gnt_unit are 0.
- Withdrawal: deasserting req before the grant is legal. The requester is simply not selected.
- Done handling: unit_done[u]=1 in cycle N with unit_busy[u]=1 and owner o produces at N+1:
  - unit_busy[u]=0, unit_owner[u]=0
  - owned[o]=0, done_to_req[o]=1
- Done processing is independent of enable.
- Spurious done: unit_done[u]=1 while unit_busy[u]=0 sets err_spurious and is otherwise ignored. err_spurious clears only on reset.
- Simultaneous done and grant in the same cycle:
  - The grant decision uses the pre-done busy vector. A unit freed at N+1 is therefore first grantable by the decision at N+1, with its grant appearing at N+2.
  - The releasing requester becomes eligible again at the N+1 decision.
- Zero-latency unit: unit_done[u] in the same cycle as unit_start[u] is legal, since busy is already 1.
- Multiple unit_done bits may be active in one cycle. All are processed in parallel.
- Pool exhausted: requests stay pending. There is no queueing beyond the req level itself.

Test Plan:
- Reset behaviour: hold rst_n=0 for 2 cycles with req=4'hF → all outputs stay 0. Release reset → gnt=0001/unit0, then 0010/unit1, then 0100/unit2 on consecutive cycles. Requester 3 waits with no grant.
- Release and reassign: from the full pool above, pulse unit_done[1] → next cycle done_to_req=0010 and unit_busy=101. The cycle after, gnt=1000 with gnt_unit=1 (ptr had reached 3).
- Round-robin fairness: hold req=1111 and return each unit the cycle after its start, with NUM_UNITS=1. Over 8 grants the sequence is 0,1,2,3,0,1,2,3 and no requester is granted twice in succession.
- Enable gating: with enable=0 and req=0001 for 5 cycles → no gnt. Units owned before enable dropped still produce done_to_req. Setting enable=1 → grant 1 cycle later.
- Spurious done: pulse unit_done[2] while unit 2 is idle → err_spurious=1 next cycle and it stays 1. unit_busy is unchanged and done_to_req=0.
- Reset mid-operation: with 3 units owned, pulse rst_n=0 for one cycle → unit_busy=000, unit_owner=0 and no done_to_req. A subsequent req=0100 is granted unit0.
